// File: rtl/jam_param_engine_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : jam_param_engine_pkg
//  Purpose  : Shared types, width helpers and parameter legality checks for
//             the exhaustive job-assignment engine.
//  Revision : 1.0  initial release
// ============================================================================
package jam_param_engine_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EVAL  = 2'd2,
    S_DONE  = 2'd3
  } jam_state_e;

  localparam int c_N_MIN   = 2;
  localparam int c_N_MAX   = 8;
  localparam int c_LAT_MAX = 2;

  // Index width for N workers/jobs, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Sum width: N costs of COST_W bits can never overflow this.
  function automatic int sum_w(input int cost_w, input int n);
    return cost_w + $clog2(n);
  endfunction

  function automatic bit params_ok(input int n, input int lat);
    return (n >= c_N_MIN) && (n <= c_N_MAX) && (lat >= 0) && (lat <= c_LAT_MAX);
  endfunction

endpackage
`default_nettype wire

// File: rtl/jam_param_engine_if.sv
`default_nettype none
// ============================================================================
//  Module   : jam_param_engine_if
//  Purpose  : Cost ROM bus. The engine (master) drives worker/job indices,
//             the ROM (slave) returns cost[W][J] after its fixed latency.
//  Revision : 1.0  initial release
// ============================================================================
interface jam_param_engine_if #(
  parameter int IDX_W  = 3,
  parameter int COST_W = 7
);
  logic [IDX_W-1:0]  W;
  logic [IDX_W-1:0]  J;
  logic [COST_W-1:0] Cost;

  modport master (output W, output J, input Cost);
  modport slave  (input W, input J, output Cost);
endinterface
`default_nettype wire

// File: rtl/jam_param_engine_next_perm.sv
`default_nettype none
// ============================================================================
//  Module   : jam_param_engine_next_perm
//  Purpose  : Combinational lexicographic successor of a permutation, plus a
//             flag marking the last (strictly descending) permutation.
//  Revision : 1.0  initial release
// ============================================================================
module jam_param_engine_next_perm #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic [N*IDX_W-1:0] i_perm,
  output logic [N*IDX_W-1:0] o_next,
  output logic               o_is_last
);

  logic [IDX_W-1:0] w_p [N];
  logic [IDX_W-1:0] w_s [N];
  logic [IDX_W-1:0] w_q [N];
  int               w_pivot;
  int               w_succ;
  logic             w_found;

  // Find pivot and successor, swap them, then reverse the tail after the pivot.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      w_p[k] = i_perm[k*IDX_W +: IDX_W];
    end

    w_found = 1'b0;
    w_pivot = 0;
    for (int k = 0; k < N - 1; k++) begin
      if (w_p[k] < w_p[k+1]) begin
        w_found = 1'b1;
        w_pivot = k;
      end
    end

    w_succ = 0;
    for (int k = 0; k < N; k++) begin
      if ((k > w_pivot) && (w_p[k] > w_p[w_pivot])) begin
        w_succ = k;
      end
    end

    w_s          = w_p;
    w_s[w_pivot] = w_p[w_succ];
    w_s[w_succ]  = w_p[w_pivot];

    w_q = w_s;
    for (int k = 0; k < N; k++) begin
      if (k > w_pivot) begin
        w_q[k] = w_s[N + w_pivot - k];
      end
    end

    o_next = '0;
    for (int k = 0; k < N; k++) begin
      o_next[k*IDX_W +: IDX_W] = w_q[k];
    end
    o_is_last = ~w_found;
  end

endmodule
`default_nettype wire

// File: rtl/jam_param_engine.sv
`default_nettype none
// ============================================================================
//  Module   : jam_param_engine
//  Purpose  : Exhaustive N x N job-assignment search. Walks all N!
//             permutations in lexicographic order, sums costs fetched from an
//             external ROM, and keeps minimum cost, tie count and first optimum.
//  Revision : 1.0  initial release
// ============================================================================
module jam_param_engine
  import jam_param_engine_pkg::*;
#(
  parameter int N       = 8,
  parameter int COST_W  = 7,
  parameter int CNT_W   = 16,
  parameter int ROM_LAT = 0,
  localparam int IDX_W  = idx_w(N),
  localparam int SUM_W  = sum_w(COST_W, N)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 Start,
  output logic                 Busy,
  jam_param_engine_if.master   rom,
  output logic                 Valid,
  output logic [SUM_W-1:0]     MinCost,
  output logic [CNT_W-1:0]     MatchCount,
  output logic [N*IDX_W-1:0]   BestPerm
);

  if (!params_ok(N, ROM_LAT)) begin : g_bad_params
    $error("jam_param_engine: N must be 2..8 and ROM_LAT 0..2");
  end

  // Fetch counter spans the N issue cycles plus the ROM latency tail.
  localparam int FC_W = $clog2(N + ROM_LAT + 1);

  function automatic logic [N*IDX_W-1:0] ident_perm();
    logic [N*IDX_W-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) begin
      v[i*IDX_W +: IDX_W] = IDX_W'(i);
    end
    return v;
  endfunction

  localparam logic [N*IDX_W-1:0] c_IDENT      = ident_perm();
  localparam logic [FC_W-1:0]    c_FETCH_LAST = FC_W'(N + ROM_LAT - 1);
  localparam logic [FC_W-1:0]    c_N_ISSUE    = FC_W'(N);

  jam_state_e           r_state;
  jam_state_e           w_next_state;
  logic [FC_W-1:0]      r_cnt;
  logic [SUM_W-1:0]     r_acc;
  logic [SUM_W-1:0]     r_min;
  logic [CNT_W-1:0]     r_match;
  logic [N*IDX_W-1:0]   r_perm;
  logic [N*IDX_W-1:0]   r_best;
  logic [N*IDX_W-1:0]   w_next_perm;
  logic                 w_is_last;
  logic                 w_fetch_last;
  logic                 w_issue;
  logic                 w_sample;
  logic [SUM_W-1:0]     w_cost_ext;

  jam_param_engine_next_perm #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_next_perm (
    .i_perm    (r_perm),
    .o_next    (w_next_perm),
    .o_is_last (w_is_last)
  );

  assign MinCost      = r_min;
  assign MatchCount   = r_match;
  assign BestPerm     = r_best;
  assign w_cost_ext   = {{(SUM_W-COST_W){1'b0}}, rom.Cost};
  assign w_fetch_last = (r_cnt == c_FETCH_LAST);
  assign w_issue      = (r_state == S_FETCH) && (r_cnt < c_N_ISSUE);
  // A cost returned for issue cycle k arrives ROM_LAT cycles later.
  assign w_sample     = (int'(r_cnt) >= ROM_LAT);

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic plus status and ROM address outputs.
  always_comb begin
    w_next_state = r_state;
    Busy         = 1'b0;
    Valid        = 1'b0;
    rom.W        = '0;
    rom.J        = '0;
    unique case (r_state)
      S_IDLE: begin
        if (Start) w_next_state = S_FETCH;
      end
      S_FETCH: begin
        Busy = 1'b1;
        if (w_fetch_last) w_next_state = S_EVAL;
      end
      S_EVAL: begin
        Busy         = 1'b1;
        w_next_state = w_is_last ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        Valid = 1'b1;
        if (Start) w_next_state = S_FETCH;
      end
      default: w_next_state = S_IDLE;
    endcase
    if (w_issue) begin
      rom.W = r_cnt[IDX_W-1:0];
      for (int k = 0; k < N; k++) begin
        if (r_cnt == FC_W'(k)) rom.J = r_perm[k*IDX_W +: IDX_W];
      end
    end
  end

  // Datapath: restart on accept, accumulate during fetch, score in eval.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_perm  <= c_IDENT;
      r_best  <= c_IDENT;
      r_min   <= '1;
      r_match <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (Start) begin
            r_perm  <= c_IDENT;
            r_min   <= '1;
            r_match <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
          end
        end
        S_FETCH: begin
          if (w_sample) r_acc <= r_acc + w_cost_ext;
          r_cnt <= w_fetch_last ? '0 : r_cnt + FC_W'(1);
        end
        S_EVAL: begin
          if (r_acc < r_min) begin
            r_min   <= r_acc;
            r_match <= CNT_W'(1);
            r_best  <= r_perm;
          end else if (r_acc == r_min) begin
            if (r_match != '1) r_match <= r_match + CNT_W'(1);
          end
          r_perm <= w_next_perm;
          r_acc  <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_jam_param_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jam_param_engine
//  Purpose  : Directed self-checking bench for jam_param_engine. Five engine
//             instances with different N / CNT_W / ROM_LAT share one clock,
//             each fed by a small cost-ROM model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_jam_param_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [4:0] rst_v;
  logic [4:0] start_v;
  wire  [4:0] busy_v;
  wire  [4:0] valid_v;
  logic       mode_a;

  // A: N=4 LAT=0   B: N=3   C: N=6 CNT_W=16   D: N=6 CNT_W=8   E: N=4 LAT=2
  logic [8:0]  min_a, min_b, min_e;
  logic [9:0]  min_c, min_d;
  logic [15:0] match_a, match_b, match_c, match_e;
  logic [7:0]  match_d;
  logic [7:0]  best_a, best_e;
  logic [5:0]  best_b;
  logic [17:0] best_c, best_d;

  jam_param_engine_if #(.IDX_W(2), .COST_W(7)) rom_a ();
  jam_param_engine_if #(.IDX_W(2), .COST_W(7)) rom_b ();
  jam_param_engine_if #(.IDX_W(3), .COST_W(7)) rom_c ();
  jam_param_engine_if #(.IDX_W(3), .COST_W(7)) rom_d ();
  jam_param_engine_if #(.IDX_W(2), .COST_W(7)) rom_e ();

  jam_param_engine #(.N(4), .COST_W(7), .CNT_W(16), .ROM_LAT(0)) u_a (
    .CLK(clk), .RST(rst_v[0]), .Start(start_v[0]), .Busy(busy_v[0]), .rom(rom_a),
    .Valid(valid_v[0]), .MinCost(min_a), .MatchCount(match_a), .BestPerm(best_a));
  jam_param_engine #(.N(3), .COST_W(7), .CNT_W(16), .ROM_LAT(0)) u_b (
    .CLK(clk), .RST(rst_v[1]), .Start(start_v[1]), .Busy(busy_v[1]), .rom(rom_b),
    .Valid(valid_v[1]), .MinCost(min_b), .MatchCount(match_b), .BestPerm(best_b));
  jam_param_engine #(.N(6), .COST_W(7), .CNT_W(16), .ROM_LAT(0)) u_c (
    .CLK(clk), .RST(rst_v[2]), .Start(start_v[2]), .Busy(busy_v[2]), .rom(rom_c),
    .Valid(valid_v[2]), .MinCost(min_c), .MatchCount(match_c), .BestPerm(best_c));
  jam_param_engine #(.N(6), .COST_W(7), .CNT_W(8), .ROM_LAT(0)) u_d (
    .CLK(clk), .RST(rst_v[3]), .Start(start_v[3]), .Busy(busy_v[3]), .rom(rom_d),
    .Valid(valid_v[3]), .MinCost(min_d), .MatchCount(match_d), .BestPerm(best_d));
  jam_param_engine #(.N(4), .COST_W(7), .CNT_W(16), .ROM_LAT(2)) u_e (
    .CLK(clk), .RST(rst_v[4]), .Start(start_v[4]), .Busy(busy_v[4]), .rom(rom_e),
    .Valid(valid_v[4]), .MinCost(min_e), .MatchCount(match_e), .BestPerm(best_e));

  // Cost ROM models: A switches between 4w+j and anti-diagonal, B is diagonal.
  always_comb begin
    if (mode_a == 1'b0) rom_a.Cost = 7'(4 * int'(rom_a.W) + int'(rom_a.J));
    else rom_a.Cost = (int'(rom_a.W) + int'(rom_a.J) == 3) ? 7'd1 : 7'd50;
    rom_b.Cost = (rom_b.W == rom_b.J) ? 7'd0 : 7'd10;
    rom_c.Cost = 7'd127;
    rom_d.Cost = 7'd127;
  end

  // Anti-diagonal ROM with a two-cycle read pipeline for instance E.
  logic [6:0] e_d1, e_d2;
  always_ff @(posedge clk) begin
    e_d1 <= (int'(rom_e.W) + int'(rom_e.J) == 3) ? 7'd1 : 7'd50;
    e_d2 <= e_d1;
  end
  assign rom_e.Cost = e_d2;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pulse Start for one edge; the engine must be busy with Valid low afterwards.
  task automatic start_run(input int idx, input string tag);
    start_v[idx] = 1'b1;
    @(posedge clk); #1;
    start_v[idx] = 1'b0;
    check_eq({tag, "_busy_after_start"}, 64'(busy_v[idx]), 64'd1);
    check_eq({tag, "_valid_drop"}, 64'(valid_v[idx]), 64'd0);
  endtask

  // Count edges since accept until Valid rises, bounded by a cycle budget.
  task automatic wait_valid(input int idx, input int start_cnt, input int exp_cyc, input string tag);
    int cyc;
    cyc = start_cnt;
    while ((valid_v[idx] !== 1'b1) && (cyc < exp_cyc + 50)) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_eq({tag, "_latency"}, 64'(cyc), 64'(exp_cyc));
    check_eq({tag, "_busy_done"}, 64'(busy_v[idx]), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_v   = 5'b11111;
    start_v = 5'b00000;
    mode_a  = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_v = 5'b00000;

    // Reset state
    check_eq("rst_busy",  64'(busy_v[0]),  64'd0);
    check_eq("rst_valid", 64'(valid_v[0]), 64'd0);
    check_eq("rst_W",     64'(rom_a.W),    64'd0);
    check_eq("rst_J",     64'(rom_a.J),    64'd0);
    check_eq("rst_min",   64'(min_a),      64'd511);
    check_eq("rst_match", 64'(match_a),    64'd0);
    check_eq("rst_best",  64'(best_a),     64'h0E4);

    // A: cost 4w+j, every assignment sums to 30
    start_run(0, "a_flat");
    wait_valid(0, 0, 120, "a_flat");
    check_eq("a_flat_min",   64'(min_a),   64'd30);
    check_eq("a_flat_match", 64'(match_a), 64'd24);
    check_eq("a_flat_best",  64'(best_a),  64'h0E4);
    check_eq("a_done_W",     64'(rom_a.W), 64'd0);

    // A: anti-diagonal, rerun from DONE
    mode_a = 1'b1;
    start_run(0, "a_anti");
    wait_valid(0, 0, 120, "a_anti");
    check_eq("a_anti_min",   64'(min_a),   64'd4);
    check_eq("a_anti_match", 64'(match_a), 64'd1);
    check_eq("a_anti_best",  64'(best_a),  64'h01B);

    // A: reset mid-fetch aborts, then a fresh run reproduces the result
    start_run(0, "a_abort");
    repeat (3) begin @(posedge clk); #1; end
    rst_v[0] = 1'b1;
    @(posedge clk); #1;
    rst_v[0] = 1'b0;
    check_eq("a_abort_busy",  64'(busy_v[0]),  64'd0);
    check_eq("a_abort_valid", 64'(valid_v[0]), 64'd0);
    check_eq("a_abort_min",   64'(min_a),      64'd511);
    start_run(0, "a_rerun");
    wait_valid(0, 0, 120, "a_rerun");
    check_eq("a_rerun_min",   64'(min_a),   64'd4);
    check_eq("a_rerun_match", 64'(match_a), 64'd1);
    check_eq("a_rerun_best",  64'(best_a),  64'h01B);

    // B: N=3 diagonal zero
    start_run(1, "b_diag");
    wait_valid(1, 0, 24, "b_diag");
    check_eq("b_diag_min",   64'(min_b),   64'd0);
    check_eq("b_diag_match", 64'(match_b), 64'd1);
    check_eq("b_diag_best",  64'(best_b),  64'h024);

    // B: Start coincident with RST, reset must win
    rst_v[1]   = 1'b1;
    start_v[1] = 1'b1;
    @(posedge clk); #1;
    rst_v[1]   = 1'b0;
    start_v[1] = 1'b0;
    check_eq("b_rst_start_busy",  64'(busy_v[1]),  64'd0);
    check_eq("b_rst_start_valid", 64'(valid_v[1]), 64'd0);
    check_eq("b_rst_start_min",   64'(min_b),      64'd511);

    // C: N=6 all 127, 720 ties
    start_run(2, "c_all");
    wait_valid(2, 0, 5040, "c_all");
    check_eq("c_all_min",   64'(min_c),   64'd762);
    check_eq("c_all_match", 64'(match_c), 64'd720);
    check_eq("c_all_best",  64'(best_c),  64'(18'o543210));

    // D: same search, 8-bit counter saturates
    start_run(3, "d_sat");
    wait_valid(3, 0, 5040, "d_sat");
    check_eq("d_sat_min",   64'(min_d),   64'd762);
    check_eq("d_sat_match", 64'(match_d), 64'd255);

    // E: ROM latency 2, Start pulses while busy are ignored
    start_run(4, "e_lat");
    repeat (3) begin
      start_v[4] = 1'b1;
      @(posedge clk); #1;
      start_v[4] = 1'b0;
      @(posedge clk); #1;
    end
    wait_valid(4, 6, 168, "e_lat");
    check_eq("e_lat_min",   64'(min_e),   64'd4);
    check_eq("e_lat_match", 64'(match_e), 64'd1);
    check_eq("e_lat_best",  64'(best_e),  64'h01B);

    // E: rerun from DONE
    start_run(4, "e_rerun");
    wait_valid(4, 0, 168, "e_rerun");
    check_eq("e_rerun_min",   64'(min_e),   64'd4);
    check_eq("e_rerun_match", 64'(match_e), 64'd1);
    check_eq("e_rerun_best",  64'(best_e),  64'h01B);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
